am_error_monitor: RTL and testbench

- Streaming error-statistics stage placed directly downstream of an unsigned approximate multiplier.
- Consumes operand pairs with their approximate product and recomputes the exact product internally.
- Accumulates error metrics over a programmable window of samples, then presents one result record through a valid/ready handshake.
- Used for on-chip characterisation of approximate multiplier variants.

---
 rtl/am_mon_pkg.sv | 10 +
 rtl/am_err_accum.sv | 65 ++++++
 rtl/am_error_monitor.sv | 111 +++++++++++
 tb/tb_am_error_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/am_mon_pkg.sv
// Shared definitions for the approximate-multiplier error monitor.
// Holds the FSM state encoding, the default widths and the pipeline depth.
package am_mon_pkg;
    localparam int W      = 8;
    localparam int CNT_W  = 16;
    localparam int SUM_W  = 2 * W + CNT_W;
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/am_err_accum.sv
// Stage 2 of the error monitor, followed by the window accumulators.
// Registers e = z - exact (signed, 2*W+1 bits) and |e| when ld is high.
// Folds the registered sample into the statistics when acc_en is high.
// clr zeroes the statistics and takes priority over acc_en.
// Ports: clk, rst (async high), clr, ld, acc_en, exact/z (stage-1 values),
//        count, sum_abs, sum_signed, max_abs, err_cnt (accumulator registers).
module am_err_accum #(
    parameter int W     = am_mon_pkg::W,
    parameter int CNT_W = am_mon_pkg::CNT_W,
    parameter int SUM_W = am_mon_pkg::SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             acc_en,
    input  logic [2*W-1:0]   exact,
    input  logic [2*W-1:0]   z,
    output logic [CNT_W-1:0] count,
    output logic [SUM_W-1:0] sum_abs,
    output logic [SUM_W:0]   sum_signed,
    output logic [2*W-1:0]   max_abs,
    output logic [CNT_W-1:0] err_cnt
);
    logic [2*W:0]   e_c, e_q;
    logic [2*W-1:0] abs_c, abs_q;

    // |e| never reaches 2^(2W), so the negated low 2W bits give the magnitude.
    always_comb begin
        e_c   = {1'b0, z} - {1'b0, exact};
        abs_c = e_c[2*W] ? (~e_c[2*W-1:0] + {{(2*W-1){1'b0}}, 1'b1})
                         : e_c[2*W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q        <= '0;
            abs_q      <= '0;
            count      <= '0;
            sum_abs    <= '0;
            sum_signed <= '0;
            max_abs    <= '0;
            err_cnt    <= '0;
        end else begin
            if (ld) begin
                e_q   <= e_c;
                abs_q <= abs_c;
            end
            if (clr) begin
                count      <= '0;
                sum_abs    <= '0;
                sum_signed <= '0;
                max_abs    <= '0;
                err_cnt    <= '0;
            end else if (acc_en) begin
                count      <= count + {{(CNT_W-1){1'b0}}, 1'b1};
                sum_abs    <= sum_abs + {{(SUM_W-2*W){1'b0}}, abs_q};
                sum_signed <= sum_signed + {{(SUM_W-2*W){e_q[2*W]}}, e_q};
                if (abs_q > max_abs)
                    max_abs <= abs_q;
                err_cnt    <= err_cnt + {{(CNT_W-1){1'b0}}, (e_q != '0)};
            end
        end
    end
endmodule

// File: rtl/am_error_monitor.sv
// Error-statistics stage placed after an unsigned approximate multiplier.
// Accepts win_len (x, y, z) samples, recomputes x*y and accumulates the error
// metrics, then holds one result record until it is taken via res_valid/res_ready.
// Ports: clk, rst (async high); start/win_len begin a window (IDLE only);
//        in_valid/in_ready/in_x/in_y/in_z sample stream;
//        res_valid/res_ready plus res_* record; busy = not IDLE.
module am_error_monitor
    import am_mon_pkg::*;
#(
    parameter int W     = am_mon_pkg::W,
    parameter int CNT_W = am_mon_pkg::CNT_W,
    parameter int SUM_W = am_mon_pkg::SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [2*W-1:0]   in_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic [SUM_W-1:0] res_sum_abs,
    output logic [SUM_W:0]   res_sum_signed,
    output logic [2*W-1:0]   res_max_abs,
    output logic [CNT_W-1:0] res_err_cnt,
    output logic             busy
);
    state_t             state;
    logic [CNT_W-1:0]   remain;
    logic [STAGES:1]    vld_pipe;
    logic [2*W-1:0]     exact_q, z_q;
    logic               accept, clr;

    assign accept = in_valid && in_ready;
    assign clr    = start && (state == IDLE);

    // Stage 1: exact product and the product under test.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exact_q <= '0;
            z_q     <= '0;
        end else if (accept) begin
            exact_q <= {{W{1'b0}}, in_x} * {{W{1'b0}}, in_y};
            z_q     <= in_z;
        end
    end

    // Control FSM; in_ready, res_valid and busy are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remain    <= '0;
            vld_pipe  <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (win_len == '0) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        state    <= RUN;
                        remain   <= win_len;
                        in_ready <= 1'b1;
                    end
                end
                RUN: if (accept) begin
                    remain <= remain - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (remain == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                // Last sample is in the accumulators once both stages are empty.
                DRAIN: if (vld_pipe == '0) begin
                    state     <= DONE;
                    res_valid <= 1'b1;
                end
                DONE: if (res_ready) begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    am_err_accum #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .ld         (vld_pipe[1]),
        .acc_en     (vld_pipe[STAGES]),
        .exact      (exact_q),
        .z          (z_q),
        .count      (res_count),
        .sum_abs    (res_sum_abs),
        .sum_signed (res_sum_signed),
        .max_abs    (res_max_abs),
        .err_cnt    (res_err_cnt)
    );
endmodule

// File: tb/tb_am_error_monitor.sv
// Scoreboard bench for am_error_monitor: stimulus pushes the hand-computed
// result record, a negedge monitor pops and compares on each result handshake.
module tb_am_error_monitor;
    import am_mon_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x, in_y;
    logic [2*W-1:0]   in_z;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_count;
    logic [SUM_W-1:0] res_sum_abs;
    logic [SUM_W:0]   res_sum_signed;
    logic [2*W-1:0]   res_max_abs;
    logic [CNT_W-1:0] res_err_cnt;
    logic             busy;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [SUM_W-1:0] sa;
        logic [SUM_W:0]   ss;
        logic [2*W-1:0]   mx;
        logic [CNT_W-1:0] ec;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    am_error_monitor dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_sum_abs(res_sum_abs),
        .res_sum_signed(res_sum_signed), .res_max_abs(res_max_abs),
        .res_err_cnt(res_err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic res_t mk(input int cnt, input int sa, input int ss, input int mx, input int ec);
        res_t r;
        r.cnt = CNT_W'(cnt);
        r.sa  = SUM_W'(sa);
        r.ss  = (SUM_W+1)'(ss);
        r.mx  = (2*W)'(mx);
        r.ec  = CNT_W'(ec);
        return r;
    endfunction

    // Result monitor.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result count=%0d", res_count);
            end else begin
                res_t e;
                e = q.pop_front();
                chk("res_count",      64'(res_count),      64'(e.cnt));
                chk("res_sum_abs",    64'(res_sum_abs),    64'(e.sa));
                chk("res_sum_signed", 64'(res_sum_signed), 64'(e.ss));
                chk("res_max_abs",    64'(res_max_abs),    64'(e.mx));
                chk("res_err_cnt",    64'(res_err_cnt),    64'(e.ec));
            end
        end
    end

    task automatic do_start(input int len);
        @(posedge clk); #1;
        start   = 1'b1;
        win_len = CNT_W'(len);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int z);
        int n = 0;
        in_x = W'(x); in_y = W'(y); in_z = (2*W)'(z);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++; fails++;
                $display("FAIL send_timeout in_ready=%0d expected=1", in_ready);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, last, rcyc, acc;
        bit pend;
        rst = 1'b1; start = 1'b0; win_len = '0; in_valid = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),    64'd0);
        chk("rst_res_valid", 64'(res_valid),   64'd0);
        chk("rst_busy",      64'(busy),        64'd0);
        chk("rst_sum_abs",   64'(res_sum_abs), 64'd0);
        chk("rst_count",     64'(res_count),   64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Exact products only.
        q.push_back(mk(4, 0, 0, 0, 0));
        do_start(4);
        chk("run_busy", 64'(busy), 64'd1);
        send(3, 5, 15); send(255, 255, 65025); send(0, 7, 0); send(128, 2, 256);
        drain("exact_drain");

        // Overestimate, worst-case underestimate, exact.
        q.push_back(mk(3, 65029, -65021, 65025, 2));
        do_start(3);
        send(2, 3, 10); send(255, 255, 0); send(10, 10, 100);
        drain("mixed_drain");

        // Backpressure with ignored start pulses.
        res_ready = 1'b0;
        q.push_back(mk(2, 4, 2, 3, 2));
        do_start(2);
        send(1, 1, 0); send(3, 3, 12);
        n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_res_valid", 64'(res_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = (i == 5); win_len = 7;
            in_valid = 1'b1; in_x = 9; in_y = 9; in_z = 0;
            @(negedge clk);
            chk("bp_stable", 64'({res_valid, in_ready, busy, res_count, res_sum_abs[15:0], res_max_abs}),
                64'({1'b1, 1'b0, 1'b1, 16'd2, 16'd4, 16'd3}));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        res_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("bp_after_valid", 64'(res_valid), 64'd0);
        chk("bp_after_busy",  64'(busy),      64'd0);
        drain("bp_drain");

        // Gapped input, every sample one above exact.
        q.push_back(mk(5, 5, 5, 1, 5));
        do_start(5);
        n = 0; last = 0; rcyc = 0; pend = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            in_x = W'(i + 1); in_y = 3; in_z = (2*W)'((i + 1) * 3 + 1);
            @(negedge clk);
            if (pend) begin chk("gap_rdy_low", 64'(in_ready), 64'd0); pend = 0; end
            if (in_valid && in_ready) begin n++; last = cyc; if (n == 5) pend = 1; end
            if (res_valid && rcyc == 0) rcyc = cyc;
        end
        in_valid = 1'b0;
        chk("gap_accepts", 64'(n), 64'd5);
        chk("gap_latency_ok", 64'((rcyc - last) >= 3), 64'd1);
        drain("gap_drain");

        // Zero-length window.
        q.push_back(mk(0, 0, 0, 0, 0));
        @(posedge clk); #1;
        start = 1'b1; win_len = 0;
        in_valid = 1'b1; in_x = 9; in_y = 9; in_z = 1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("zero_res_valid", 64'(res_valid), 64'd1);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_valid && in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("zero_no_accept", 64'(acc), 64'd0);
        drain("zero_drain");

        // Reset in the middle of a window.
        do_start(6);
        send(5, 5, 0); send(5, 5, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_sum_abs", 64'(res_sum_abs), 64'd0);
        chk("mid_rst_count",   64'(res_count),   64'd0);
        chk("mid_rst_busy",    64'(busy),        64'd0);
        chk("mid_rst_ready",   64'(in_ready),    64'd0);
        chk("mid_rst_rvalid",  64'(res_valid),   64'd0);
        @(posedge clk); #1 rst = 1'b0;
        q.push_back(mk(1, 1, 1, 1, 1));
        do_start(1);
        send(4, 4, 17);
        drain("post_rst_drain");
        chk("final_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
